rv32_pc_unit: RTL and testbench
===============================

RV32_PC_UNIT -- requirements
Module: rv32_pc_unit

Interface
REQ-001 Parameter XLEN, default 32: PC and target width.
REQ-002 Parameter RESET_VECTOR, default 32'h0000_0000: PC value loaded by reset.
REQ-003 Parameter TRAP_VECTOR, default 32'h0000_0100: PC value loaded on trap.
REQ-004 Parameter RAS_DEPTH, default 4 (power of 2, at least 2): return-address-stack entries.
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and reset_n.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 reset_n  input  1  asynchronous active-low reset.
REQ-008 stall_i  input  1  hold PC.
REQ-009 redirect_i  input  1  branch/jump taken.
REQ-010 redirect_pc_i  input  XLEN  redirect target.
REQ-011 call_i  input  1  qualifies redirect_i as a call; push return address.
REQ-012 ret_i  input  1  return; pop RAS.
REQ-013 trap_i  input  1  exception/interrupt entry.
REQ-014 mret_i  input  1  trap return.
REQ-015 pc_o  output  XLEN  current fetch PC.
REQ-016 pc_plus4_o  output  XLEN  pc_o + 4, combinational.
REQ-017 pc_valid_o  output  1  pc_o is a valid fetch address.
REQ-018 mepc_o  output  XLEN  saved trap PC.
REQ-019 misaligned_o  output  1  registered one-cycle pulse: rejected misaligned target.
REQ-020 bad_addr_o  output  XLEN  last rejected target.
REQ-021 ras_empty_o  output  1  RAS holds no entries.

Function
REQ-022 Next-PC priority, evaluated each rising edge: trap_i > mret_i > redirect_i > ret_i > stall_i > sequential.
REQ-023 trap_i: pc_o <= TRAP_VECTOR; mepc_o <= current pc_o.
REQ-024 mret_i: pc_o <= mepc_o.
REQ-025 redirect_i with redirect_pc_i[1:0]==0: pc_o <= redirect_pc_i.
REQ-026 redirect_i with redirect_pc_i[1:0]!=0: pc_o holds; misaligned_o=1 next cycle; bad_addr_o <= redirect_pc_i; no RAS push.
REQ-027 redirect_i with call_i and aligned target: push pc_plus4_o onto RAS in the same edge.
REQ-028 ret_i with RAS non-empty: pc_o <= top entry; pop.
REQ-029 ret_i with RAS empty: pc_o <= pc_plus4_o; no pop; count stays 0.
REQ-030 Push on full RAS: overwrite oldest entry (circular); count saturates at RAS_DEPTH.
REQ-031 call_i or ret_i without a winning redirect_i or ret_i path: no RAS change; a lower-priority RAS operation loses to trap_i/mret_i.
REQ-032 stall_i alone: pc_o, RAS and mepc_o hold; pc_valid_o unchanged.
REQ-033 Sequential: pc_o <= pc_o + 4, modulo 2^XLEN; 0xFFFF_FFFC wraps to 0.
REQ-034 pc_valid_o=0 for exactly one cycle after any PC change by trap, mret, redirect or ret (bubble); otherwise 1.
REQ-035 misaligned_o SHALL deassert on the following edge unless re-triggered.

Reset
REQ-036 While reset_n=0, asynchronously: pc_o=RESET_VECTOR, mepc_o=0, bad_addr_o=0, misaligned_o=0, pc_valid_o=0, RAS count=0, ras_empty_o=1.
REQ-037 First rising edge after reset_n rises: pc_valid_o=1, pc_o stays RESET_VECTOR; the sequential advance starts on the next edge.
REQ-038 Reset asserted mid-operation SHALL override every input within the same cycle; RAS contents are discarded.

Verification
REQ-039 Reset release, no inputs for 3 cycles -> pc_o 0x0, 0x0, 0x4, 0x8; pc_valid_o 0 then 1.
REQ-040 redirect_i+call_i to 0x200 at pc 0x10, then ret_i -> pc 0x200, then 0x14; ras_empty_o 1->0->1; pc_valid_o 0 after each jump.
REQ-041 redirect_pc_i=0x202 -> pc_o holds, misaligned_o pulses once, bad_addr_o=0x202.
REQ-042 trap_i and redirect_i together at pc 0x40 -> pc_o=0x100, mepc_o=0x40; later mret_i -> pc_o=0x40.
REQ-043 RAS_DEPTH+1 calls then RAS_DEPTH+1 returns -> last RAS_DEPTH returns pop in LIFO order (first-pushed lost); final ret_i falls through to pc+4.
REQ-044 stall_i held 3 cycles at 0x8 -> pc_o stays 0x8; reset_n pulsed low mid-stall -> pc_o=0x0 immediately.

Source files
------------

// File: rtl/rv32_pc_unit.sv
// RV32 fetch program counter: trap/mret/redirect/return/stall/sequential next-PC
// selection with a circular return-address stack and misaligned-target rejection.
module rv32_pc_unit #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h0000_0000),
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
  parameter int unsigned     RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            call_i,
  input  logic            ret_i,
  input  logic            trap_i,
  input  logic            mret_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic            pc_valid_o,
  output logic [XLEN-1:0] mepc_o,
  output logic            misaligned_o,
  output logic [XLEN-1:0] bad_addr_o,
  output logic            ras_empty_o
);

  localparam int unsigned PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CW = $clog2(RAS_DEPTH + 1);

  logic [XLEN-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]   ras_top;
  logic [CW-1:0]   ras_count;
  logic            started;

  logic do_trap, do_mret, redir_ok, redir_bad, do_ret, do_seq;
  logic ras_push, ras_pop;

  assign pc_plus4_o  = pc_o + XLEN'(4);
  assign ras_empty_o = (ras_count == '0);

  // Nothing advances on the first edge after reset release; only pc_valid_o rises.
  always_comb begin
    do_trap   = 1'b0;
    do_mret   = 1'b0;
    redir_ok  = 1'b0;
    redir_bad = 1'b0;
    do_ret    = 1'b0;
    do_seq    = 1'b0;
    if (started) begin
      if (trap_i)                               do_trap   = 1'b1;
      else if (mret_i)                          do_mret   = 1'b1;
      else if (redirect_i) begin
        if (redirect_pc_i[1:0] == 2'b00)        redir_ok  = 1'b1;
        else                                    redir_bad = 1'b1;
      end
      else if (ret_i)                           do_ret    = 1'b1;
      else if (!stall_i)                        do_seq    = 1'b1;
    end
    ras_push = redir_ok & call_i;
    ras_pop  = do_ret & ~ras_empty_o;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_o         <= RESET_VECTOR;
      mepc_o       <= '0;
      bad_addr_o   <= '0;
      misaligned_o <= 1'b0;
      pc_valid_o   <= 1'b0;
      started      <= 1'b0;
      ras_top      <= '0;
      ras_count    <= '0;
    end else begin
      misaligned_o <= redir_bad;
      if (!started) begin
        started    <= 1'b1;
        pc_valid_o <= 1'b1;
      end
      if (do_trap) begin
        pc_o       <= TRAP_VECTOR;
        mepc_o     <= pc_o;
        pc_valid_o <= 1'b0;
      end else if (do_mret) begin
        pc_o       <= mepc_o;
        pc_valid_o <= 1'b0;
      end else if (redir_ok) begin
        pc_o       <= redirect_pc_i;
        pc_valid_o <= 1'b0;
      end else if (redir_bad) begin
        bad_addr_o <= redirect_pc_i;
        pc_valid_o <= 1'b1;
      end else if (do_ret) begin
        pc_o       <= ras_pop ? ras_mem[ras_top] : pc_plus4_o;
        pc_valid_o <= 1'b0;
      end else if (do_seq) begin
        pc_o       <= pc_plus4_o;
        pc_valid_o <= 1'b1;
      end
      // A push on a full stack lands on the oldest slot; the count just saturates.
      if (ras_push) begin
        ras_top <= ras_top + PW'(1);
        if (ras_count != CW'(RAS_DEPTH)) ras_count <= ras_count + CW'(1);
      end else if (ras_pop) begin
        ras_top   <= ras_top - PW'(1);
        ras_count <= ras_count - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ras_push) ras_mem[ras_top + PW'(1)] <= pc_plus4_o;
  end

endmodule

// File: tb/tb_rv32_pc_unit.sv
// Self-checking bench for rv32_pc_unit: directed scenarios followed by random
// stimulus, all compared against a queue-based behavioural model.
module tb_rv32_pc_unit;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] TVEC  = 32'h0000_0100;
  localparam logic [31:0] RVEC  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall_i, redirect_i, call_i, ret_i, trap_i, mret_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] pc_o, pc_plus4_o, mepc_o, bad_addr_o;
  logic        pc_valid_o, misaligned_o, ras_empty_o;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [31:0] m_pc, m_mepc, m_bad;
  logic        m_valid, m_mis, m_started;
  logic [31:0] ras_q[$];

  rv32_pc_unit #(
    .XLEN(XLEN), .RESET_VECTOR(RVEC), .TRAP_VECTOR(TVEC), .RAS_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset_n(reset_n), .stall_i(stall_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .call_i(call_i), .ret_i(ret_i),
    .trap_i(trap_i), .mret_i(mret_i), .pc_o(pc_o), .pc_plus4_o(pc_plus4_o),
    .pc_valid_o(pc_valid_o), .mepc_o(mepc_o), .misaligned_o(misaligned_o),
    .bad_addr_o(bad_addr_o), .ras_empty_o(ras_empty_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RVEC; m_mepc = '0; m_bad = '0;
    m_valid = 1'b0; m_mis = 1'b0; m_started = 1'b0;
    ras_q.delete();
  endtask

  task automatic model_edge(input logic tr, input logic mr, input logic rd,
                            input logic [31:0] rpc, input logic cl,
                            input logic rt, input logic st);
    if (!m_started) begin
      m_started = 1'b1; m_valid = 1'b1; m_mis = 1'b0;
      return;
    end
    m_mis = 1'b0;
    if (tr) begin
      m_mepc = m_pc; m_pc = TVEC; m_valid = 1'b0;
    end else if (mr) begin
      m_pc = m_mepc; m_valid = 1'b0;
    end else if (rd) begin
      if (rpc % 4 != 0) begin
        m_mis = 1'b1; m_bad = rpc; m_valid = 1'b1;
      end else begin
        if (cl) begin
          ras_q.push_back(m_pc + 4);
          if (ras_q.size() > DEPTH) void'(ras_q.pop_front());
        end
        m_pc = rpc; m_valid = 1'b0;
      end
    end else if (rt) begin
      m_pc = (ras_q.size() > 0) ? ras_q.pop_back() : m_pc + 4;
      m_valid = 1'b0;
    end else if (!st) begin
      m_pc = m_pc + 4; m_valid = 1'b1;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"},        pc_o,              m_pc);
    chk({tag, ".pc4"},       pc_plus4_o,        m_pc + 32'd4);
    chk({tag, ".valid"},     32'(pc_valid_o),   32'(m_valid));
    chk({tag, ".mepc"},      mepc_o,            m_mepc);
    chk({tag, ".mis"},       32'(misaligned_o), 32'(m_mis));
    chk({tag, ".bad"},       bad_addr_o,        m_bad);
    chk({tag, ".empty"},     32'(ras_empty_o),  32'(ras_q.size() == 0));
  endtask

  // Starts and ends just after a falling edge.
  task automatic step(input string tag, input logic tr, input logic mr, input logic rd,
                      input logic [31:0] rpc, input logic cl, input logic rt,
                      input logic st);
    trap_i = tr; mret_i = mr; redirect_i = rd; redirect_pc_i = rpc;
    call_i = cl; ret_i = rt; stall_i = st;
    @(posedge clk);
    model_edge(tr, mr, rd, rpc, cl, rt, st);
    #1;
    check_all(tag);
    @(negedge clk);
  endtask

  task automatic idle(input string tag);
    step(tag, 0, 0, 0, 32'h0, 0, 0, 0);
  endtask

  task automatic jump(input string tag, input logic [31:0] t, input logic cl);
    step(tag, 0, 0, 1, t, cl, 0, 0);
  endtask

  logic [31:0] ra [DEPTH+1];

  initial begin
    reset_n = 1'b0;
    {stall_i, redirect_i, call_i, ret_i, trap_i, mret_i} = '0;
    redirect_pc_i = '0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check_all("rst");
    chk("rst.pc_const", pc_o, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // Reset release: 0, 0, 4, 8
    idle("rel1"); chk("rel1.pc", pc_o, 32'h0); chk("rel1.v", 32'(pc_valid_o), 32'h1);
    idle("rel2"); chk("rel2.pc", pc_o, 32'h4);
    idle("rel3"); chk("rel3.pc", pc_o, 32'h8);

    // Call / return
    idle("s4"); idle("s5"); chk("at10", pc_o, 32'h10);
    jump("call", 32'h200, 1);
    chk("call.pc", pc_o, 32'h200); chk("call.empty", 32'(ras_empty_o), 32'h0);
    chk("call.v", 32'(pc_valid_o), 32'h0);
    step("ret", 0, 0, 0, 32'h0, 0, 1, 0);
    chk("ret.pc", pc_o, 32'h14); chk("ret.empty", 32'(ras_empty_o), 32'h1);
    chk("ret.v", 32'(pc_valid_o), 32'h0);

    // Misaligned redirect
    jump("mis", 32'h202, 1);
    chk("mis.pc", pc_o, 32'h14); chk("mis.pulse", 32'(misaligned_o), 32'h1);
    chk("mis.bad", bad_addr_o, 32'h202); chk("mis.nopush", 32'(ras_empty_o), 32'h1);
    idle("mis2"); chk("mis2.pulse", 32'(misaligned_o), 32'h0);

    // Trap beats redirect, then mret
    jump("to40", 32'h40, 0);
    step("trap", 1, 0, 1, 32'h300, 1, 0, 0);
    chk("trap.pc", pc_o, 32'h100); chk("trap.mepc", mepc_o, 32'h40);
    chk("trap.nopush", 32'(ras_empty_o), 32'h1);
    idle("trap2");
    step("mret", 0, 1, 0, 32'h0, 0, 0, 0);
    chk("mret.pc", pc_o, 32'h40);

    // RAS overflow: DEPTH+1 calls, DEPTH+1 returns
    ra[0] = 32'h44;
    for (int i = 0; i <= DEPTH; i++) begin
      jump("ovf.call", 32'h1000 + 32'h100 * i, 1);
      if (i < DEPTH) ra[i+1] = 32'h1000 + 32'h100 * i + 4;
    end
    for (int j = 0; j < DEPTH; j++) begin
      step("ovf.ret", 0, 0, 0, 32'h0, 0, 1, 0);
      chk("ovf.lifo", pc_o, ra[DEPTH - j]);
    end
    step("ovf.last", 0, 0, 0, 32'h0, 0, 1, 0);
    chk("ovf.fall", pc_o, ra[1] + 32'd4);
    chk("ovf.empty", 32'(ras_empty_o), 32'h1);

    // Wrap
    jump("wrapj", 32'hFFFF_FFFC, 0);
    idle("wrap"); chk("wrap.pc", pc_o, 32'h0);

    // Stall at 0x8, reset mid-stall
    jump("to8", 32'h8, 1);
    idle("to8b"); jump("to8c", 32'h8, 0);
    for (int k = 0; k < 3; k++) begin
      step("stall", 0, 0, 0, 32'h0, 0, 0, 1);
      chk("stall.pc", pc_o, 32'h8);
    end
    stall_i = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    chk("arst.pc", pc_o, 32'h0);
    check_all("arst");
    @(negedge clk);
    reset_n = 1'b1;
    stall_i = 1'b0;
    idle("post1"); idle("post2"); chk("post2.pc", pc_o, 32'h4);

    // Random stimulus
    for (int n = 0; n < 400; n++) begin
      logic [31:0] t;
      t = $urandom & 32'h0000_FFFC;
      if ($urandom_range(0, 9) == 0) t = t | 32'($urandom_range(1, 3));
      step("rnd",
           $urandom_range(0, 99) < 4, $urandom_range(0, 99) < 5,
           $urandom_range(0, 99) < 25, t, $urandom_range(0, 1) == 1,
           $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 20);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
